// File: rtl/matvec_engine.sv
`default_nettype none
// ============================================================================
// Module      : matvec_engine
// Description : N x N matrix times N-vector engine (C = A x B). Fetches the
//               N rows of A and the vector B over an Avalon-MM read master,
//               then sweeps one column per cycle across N parallel MAC lanes.
//               Results stay on c_out until the next accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
module matvec_engine #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(N),
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      signed_mode,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  output logic [ADDR_WIDTH-1:0]     mm_address,
  output logic                      mm_read,
  input  logic [N*DATA_WIDTH-1:0]   mm_readdata,
  input  logic                      mm_readdatavalid,
  input  logic                      mm_waitrequest,
  output logic [N*ACC_WIDTH-1:0]    c_out,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                current_state
);

  // Counters span 0..N+1 words; column counter spans 0..N-1.
  localparam int CNT_W = $clog2(N+2);
  localparam int COL_W = $clog2(N);
  // Products are formed at a width that holds both the full product and the
  // accumulator, so the low ACC_WIDTH bits are the correctly extended product.
  localparam int EXT_W = (ACC_WIDTH > 2*DATA_WIDTH) ? ACC_WIDTH : 2*DATA_WIDTH;

  localparam logic [CNT_W-1:0] C_WORDS    = CNT_W'(N+1);
  localparam logic [CNT_W-1:0] C_LAST_RSP = CNT_W'(N);
  localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(N-1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_COMPUTE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [CNT_W-1:0]         r_issue_cnt;
  logic [CNT_W-1:0]         r_rsp_cnt;
  logic [COL_W-1:0]         r_col;
  logic [ADDR_WIDTH-1:0]    r_base;
  logic                     r_signed;
  logic                     r_done;
  logic [N*DATA_WIDTH-1:0]  r_rows [0:N];
  logic [ACC_WIDTH-1:0]     r_acc  [N];
  logic [ACC_WIDTH-1:0]     w_prod [N];

  logic                     w_start_ok;
  logic                     w_issue;
  logic                     w_accept;
  logic                     w_capture;
  logic                     w_last_rsp;
  logic                     w_last_col;
  logic [DATA_WIDTH-1:0]    w_b;
  logic [EXT_W-1:0]         w_b_ext;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_issue    = (r_state == S_FETCH) && (r_issue_cnt < C_WORDS);
  assign w_accept   = w_issue && !mm_waitrequest;
  // Responses outside FETCH or beyond the N+1 expected words are dropped.
  assign w_capture  = (r_state == S_FETCH) && mm_readdatavalid && (r_rsp_cnt < C_WORDS);
  assign w_last_rsp = w_capture && (r_rsp_cnt == C_LAST_RSP);
  assign w_last_col = (r_state == S_COMPUTE) && (r_col == C_LAST_COL);

  assign mm_read       = w_issue;
  assign mm_address    = w_issue ? (r_base + ADDR_WIDTH'(r_issue_cnt)) : '0;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign current_state = r_state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start)      w_state_next = S_FETCH;
      S_FETCH:   if (w_last_rsp) w_state_next = S_COMPUTE;
      S_COMPUTE: if (w_last_col) w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // Run configuration, request/response counters and column index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_rsp_cnt   <= '0;
      r_col       <= '0;
      r_base      <= '0;
      r_signed    <= 1'b0;
    end else if (w_start_ok) begin
      r_issue_cnt <= '0;
      r_rsp_cnt   <= '0;
      r_col       <= '0;
      r_base      <= base_addr;
      r_signed    <= signed_mode;
    end else begin
      if (w_accept)                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (w_capture)               r_rsp_cnt   <= r_rsp_cnt + CNT_W'(1);
      if (w_last_rsp)              r_col       <= '0;
      else if (r_state == S_COMPUTE) r_col     <= r_col + COL_W'(1);
    end
  end

  // Row storage: slots 0..N-1 hold rows of A, slot N holds B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r <= N; r++) r_rows[r] <= '0;
    end else if (w_capture) begin
      r_rows[r_rsp_cnt] <= mm_readdata;
    end
  end

  // Sticky completion flag, cleared when a new run is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_done <= 1'b0;
    else if (w_start_ok) r_done <= 1'b0;
    else if (w_last_col) r_done <= 1'b1;
  end

  assign w_b     = r_rows[N][r_col*DATA_WIDTH +: DATA_WIDTH];
  assign w_b_ext = r_signed ? {{(EXT_W-DATA_WIDTH){w_b[DATA_WIDTH-1]}}, w_b}
                            : {{(EXT_W-DATA_WIDTH){1'b0}}, w_b};

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] w_a;
      logic [EXT_W-1:0]      w_a_ext;
      logic [EXT_W-1:0]      w_full;
      assign w_a       = r_rows[i][r_col*DATA_WIDTH +: DATA_WIDTH];
      assign w_a_ext   = r_signed ? {{(EXT_W-DATA_WIDTH){w_a[DATA_WIDTH-1]}}, w_a}
                                  : {{(EXT_W-DATA_WIDTH){1'b0}}, w_a};
      assign w_full    = w_a_ext * w_b_ext;
      assign w_prod[i] = w_full[ACC_WIDTH-1:0];
      assign c_out[i*ACC_WIDTH +: ACC_WIDTH] = r_acc[i];
    end
  endgenerate

  // Accumulators: cleared on start, one MAC per lane per COMPUTE cycle (wraps)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_acc[i] <= '0;
    end else if (w_start_ok) begin
      for (int i = 0; i < N; i++) r_acc[i] <= '0;
    end else if (r_state == S_COMPUTE) begin
      for (int i = 0; i < N; i++) r_acc[i] <= r_acc[i] + w_prod[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matvec_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_matvec_engine
// Description : Self-checking bench for matvec_engine with an Avalon-MM
//               memory model (random stall / latency) and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matvec_engine;

  localparam int N   = 8;
  localparam int DW  = 8;
  localparam int ACC = 2*DW + $clog2(N);
  localparam int A16 = 16;

  typedef struct {
    logic [N*ACC-1:0] c19;
    logic [N*A16-1:0] c16;
  } exp_t;

  typedef struct {
    logic [N*DW-1:0] data;
    int              due;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             signed_mode;
  logic [31:0]      base_addr;
  logic [31:0]      mm_address;
  logic             mm_read;
  logic [N*DW-1:0]  mm_readdata;
  logic             mm_readdatavalid;
  logic             mm_waitrequest;
  logic [N*ACC-1:0] c_out;
  logic             busy;
  logic             done;
  logic [1:0]       current_state;

  logic [31:0]      mm_address16;
  logic             mm_read16;
  logic [N*A16-1:0] c_out16;
  logic             busy16;
  logic             done16;
  logic [1:0]       state16;

  logic [N*DW-1:0]  mem [0:255];
  exp_t             exp_q[$];
  rsp_t             pend_q[$];
  rsp_t             rsp_new;
  logic [31:0]      addr_log[$];
  int               cyc = 0;
  int               rsp_seen = 0;
  int               last_rsp_cyc = 0;
  bit               prev_busy = 1'b0;
  bit               rand_wait = 1'b0;
  int               lat_max = 0;
  int               n_cmp = 0;
  int               n_bad = 0;

  always #5 clk = ~clk;

  matvec_engine #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .base_addr(base_addr), .mm_address(mm_address), .mm_read(mm_read),
    .mm_readdata(mm_readdata), .mm_readdatavalid(mm_readdatavalid),
    .mm_waitrequest(mm_waitrequest), .c_out(c_out), .busy(busy), .done(done),
    .current_state(current_state)
  );

  // Same bus inputs, narrow accumulator to exercise wrap-around
  matvec_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(A16), .ADDR_WIDTH(32)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .base_addr(base_addr), .mm_address(mm_address16), .mm_read(mm_read16),
    .mm_readdata(mm_readdata), .mm_readdatavalid(mm_readdatavalid),
    .mm_waitrequest(mm_waitrequest), .c_out(c_out16), .busy(busy16), .done(done16),
    .current_state(state16)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: decides stall for the next edge, queues accepted reads with
  // random latency, and returns them in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
      mm_waitrequest   = 1'b0;
      mm_readdatavalid = 1'b0;
      mm_readdata      = '0;
      prev_busy        = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        addr_log.delete();
        rsp_seen = 0;
      end
      prev_busy = busy;
      mm_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (mm_read && !mm_waitrequest) begin
        rsp_new.data = mem[mm_address[7:0]];
        rsp_new.due  = cyc + 2 + ((lat_max > 0) ? int'($urandom_range(0, lat_max)) : 0);
        pend_q.push_back(rsp_new);
        addr_log.push_back(mm_address);
      end
      if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
        mm_readdatavalid = 1'b1;
        mm_readdata      = pend_q[0].data;
        void'(pend_q.pop_front());
        rsp_seen++;
        if (rsp_seen == N + 1) last_rsp_cyc = cyc + 1;
      end else begin
        mm_readdatavalid = 1'b0;
        mm_readdata      = '0;
      end
    end
  end

  // Reference model: plain integer dot products reduced to each width
  function automatic void compute_exp(input logic [31:0] base, input logic sm,
                                      output logic [N*ACC-1:0] c19,
                                      output logic [N*A16-1:0] c16);
    longint     s, a, b;
    logic [7:0] av, bv;
    logic [7:0] ba;
    ba = base[7:0];
    c19 = '0;
    c16 = '0;
    for (int i = 0; i < N; i++) begin
      s = 0;
      for (int k = 0; k < N; k++) begin
        av = mem[ba + 8'(i)][k*DW +: DW];
        bv = mem[ba + 8'(N)][k*DW +: DW];
        a  = sm ? longint'($signed(av)) : longint'(av);
        b  = sm ? longint'($signed(bv)) : longint'(bv);
        s  = s + a * b;
      end
      c19[i*ACC +: ACC] = s[ACC-1:0];
      c16[i*A16 +: A16] = s[A16-1:0];
    end
  endfunction

  task automatic fill(input logic [7:0] base, input int mode);
    // mode 0: identity/B=1..N, 1: A=FF B=02, 2: all FF, 3: random
    for (int r = 0; r <= N; r++)
      for (int j = 0; j < N; j++) begin
        case (mode)
          0:       mem[base + 8'(r)][j*DW +: DW] = (r == N) ? 8'(j + 1) : ((r == j) ? 8'd1 : 8'd0);
          1:       mem[base + 8'(r)][j*DW +: DW] = (r == N) ? 8'h02 : 8'hFF;
          2:       mem[base + 8'(r)][j*DW +: DW] = 8'hFF;
          default: mem[base + 8'(r)][j*DW +: DW] = 8'($urandom);
        endcase
      end
  endtask

  // One full run from a negedge; pushes expectation at start, pops at done.
  task automatic do_run(input logic [31:0] base, input logic sm, input bit poke, input bit chk_time);
    exp_t e;
    bit   seen;
    compute_exp(base, sm, e.c19, e.c16);
    exp_q.push_back(e);
    base_addr   = base;
    signed_mode = sm;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    base_addr   = 32'hDEAD_0000;
    signed_mode = ~sm;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL accept_busy got %b want 1", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL accept_done got %b want 0", done); end
    n_cmp++; if (c_out !== '0 || c_out16 !== '0) begin n_bad++; $display("FAIL accept_clear got %h / %h want 0", c_out, c_out16); end
    n_cmp++; if (mm_read !== 1'b1 || mm_address !== base) begin n_bad++; $display("FAIL accept_addr got rd=%b addr=%h want rd=1 addr=%h", mm_read, mm_address, base); end
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
      if (poke) begin start = c[0]; base_addr = 32'h99; end
    end
    start = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL run_timeout got done=%b want 1 within 400 cycles", done);
    end else if (exp_q.size() == 0) begin
      n_bad++; $display("FAIL scoreboard_empty got 0 entries want 1");
    end else begin
      e = exp_q.pop_front();
      if (c_out !== e.c19) begin n_bad++; $display("FAIL result got %h want %h", c_out, e.c19); end
      n_cmp++; if (c_out16 !== e.c16) begin n_bad++; $display("FAIL result16 got %h want %h", c_out16, e.c16); end
      n_cmp++; if (busy !== 1'b0 || current_state !== 2'd0) begin n_bad++; $display("FAIL end_state got busy=%b st=%0d want 0/0", busy, current_state); end
      if (chk_time) begin
        n_cmp++; if (cyc - last_rsp_cyc != N) begin n_bad++; $display("FAIL done_latency got %0d want %0d", cyc - last_rsp_cyc, N); end
      end
      n_cmp++;
      if (addr_log.size() != N + 1) begin
        n_bad++; $display("FAIL addr_count got %0d want %0d", addr_log.size(), N + 1);
      end else begin
        for (int k = 0; k <= N; k++)
          if (addr_log[k] !== base + 32'(k)) begin
            n_bad++; $display("FAIL addr_seq[%0d] got %h want %h", k, addr_log[k], base + 32'(k)); break;
          end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++; if (mm_address !== '0) begin n_bad++; $display("FAIL %s mm_address got %h want 0", tag, mm_address); end
    n_cmp++; if (mm_read !== 1'b0) begin n_bad++; $display("FAIL %s mm_read got %b want 0", tag, mm_read); end
    n_cmp++; if (c_out !== '0) begin n_bad++; $display("FAIL %s c_out got %h want 0", tag, c_out); end
    n_cmp++; if (c_out16 !== '0) begin n_bad++; $display("FAIL %s c_out16 got %h want 0", tag, c_out16); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy got %b want 0", tag, busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s done got %b want 0", tag, done); end
    n_cmp++; if (current_state !== 2'd0) begin n_bad++; $display("FAIL %s state got %0d want 0", tag, current_state); end
  endtask

  task automatic test_reset;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity;
    rand_wait = 1'b0; lat_max = 0;
    fill(8'h00, 0);
    do_run(32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      n_cmp++; if (c_out[i*ACC +: ACC] !== ACC'(i + 1)) begin n_bad++; $display("FAIL identity C[%0d] got %0d want %0d", i, c_out[i*ACC +: ACC], i + 1); end
    end
  endtask

  task automatic test_signed;
    fill(8'h00, 1);
    do_run(32'h0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (c_out[0 +: ACC] !== 19'h7FFF0 || c_out16[0 +: A16] !== 16'hFFF0) begin n_bad++; $display("FAIL signed_neg16 got %h/%h want 7fff0/fff0", c_out[0 +: ACC], c_out16[0 +: A16]); end
    do_run(32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (c_out[(N-1)*ACC +: ACC] !== 19'd4080) begin n_bad++; $display("FAIL unsigned_ff02 got %0d want 4080", c_out[(N-1)*ACC +: ACC]); end
  endtask

  task automatic test_max_unsigned;
    fill(8'h00, 2);
    do_run(32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (c_out[3*ACC +: ACC] !== 19'd520200) begin n_bad++; $display("FAIL max19 got %0d want 520200", c_out[3*ACC +: ACC]); end
    n_cmp++; if (c_out16[3*A16 +: A16] !== 16'd61448) begin n_bad++; $display("FAIL max16 got %0d want 61448", c_out16[3*A16 +: A16]); end
  endtask

  task automatic test_backpressure;
    rand_wait = 1'b1; lat_max = 4;
    fill(8'h40, 3);
    do_run(32'h40, 1'b0, 1'b0, 1'b1);
    fill(8'h40, 3);
    do_run(32'h40, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    rand_wait = 1'b0; lat_max = 2;
    fill(8'h10, 3);
    do_run(32'h10, 1'b1, 1'b1, 1'b0);
    fill(8'h80, 3);
    do_run(32'h80, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_compute;
    bit hit;
    rand_wait = 1'b0; lat_max = 0;
    fill(8'h20, 2);
    base_addr = 32'h20; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (current_state === 2'd2) begin hit = 1'b1; break; end
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL reach_compute got state=%0d want 2", current_state); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(8'h20, 3);
    do_run(32'h20, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; base_addr = '0;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_identity();
    test_signed();
    test_max_unsigned();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_compute();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
